// File: rtl/idma_aw_burst_sched_pkg.sv
// Shared types, AXI constants and the burst-size helper for the DMA
// write-address scheduler.
package idma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         PAGE_BYTES     = 4096;

    // Beats of the next burst: the smallest of the remaining beats, the
    // burst-length cap and the beats left before the next 4 KB page.
    // addr is the page offset, size is log2 of the bytes per beat.
    function automatic logic [8:0] calc_beats(
        input logic [11:0] addr,
        input logic [31:0] rem,
        input logic [8:0]  max,
        input logic [2:0]  size
    );
        logic [12:0] room_bytes;
        logic [31:0] room;
        logic [31:0] n;
        room_bytes = 13'(PAGE_BYTES) - {1'b0, addr};
        room       = 32'(room_bytes >> size);
        n          = rem;
        if ({23'd0, max} < n) n = {23'd0, max};
        if (room < n)         n = room;
        return n[8:0];
    endfunction

endpackage

// File: rtl/idma_aw_burst_sched_if.sv
// Descriptor, AW, B and completion signals of the DMA write-address
// scheduler. master = scheduler side, slave = requesters/interconnect side.
// Optional perf counter signals exist only with IDMA_AW_SCHED_PERF_EN.
interface idma_aw_burst_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_bytes;

    logic                      awvalid;
    logic                      awready;
    logic [ADDR_W-1:0]         awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [ID_W-1:0]           awid;

    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;

    logic                      done_valid;
    logic [ID_W-1:0]           done_id;
    logic                      done_err;
    logic                      busy;
`ifdef IDMA_AW_SCHED_PERF_EN
    logic [31:0]               perf_bursts;
    logic [31:0]               perf_stall;
`endif

    modport master (
        input  req_valid, req_addr, req_bytes, awready, bvalid, bresp,
        output req_ready, awvalid, awaddr, awlen, awsize, awburst, awid,
        output bready, done_valid, done_id, done_err, busy
`ifdef IDMA_AW_SCHED_PERF_EN
        , output perf_bursts, perf_stall
`endif
    );

    modport slave (
        output req_valid, req_addr, req_bytes, awready, bvalid, bresp,
        input  req_ready, awvalid, awaddr, awlen, awsize, awburst, awid,
        input  bready, done_valid, done_id, done_err, busy
`ifdef IDMA_AW_SCHED_PERF_EN
        , input perf_bursts, perf_stall
`endif
    );

endinterface

// File: rtl/idma_aw_burst_sched_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner when the grant is taken.
module idma_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_advance,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] r_ptr;

    // Rotating priority search starting at the pointer.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int  idx;
            idx = int'(r_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (o_grant == '0 && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                o_grant_idx  = ID_W'(idx);
            end
        end
    end

    // Pointer update to the requester after the winner, wrapping at NUM_REQ.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr <= '0;
        end else if (i_advance && o_grant != '0) begin
            r_ptr <= (o_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/idma_aw_burst_sched.sv
// DMA write-address scheduler: grants descriptors round-robin, splits them
// into INCR bursts (length cap, no 4 KB crossing), caps outstanding bursts,
// and reports completion with a sticky error flag.
// Optional: define IDMA_AW_SCHED_PERF_EN for saturating perf counters.
module idma_aw_burst_sched
    import idma_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BEATS = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    idma_aw_burst_sched_if.master bus
);
    localparam int BEAT_B = DATA_W / 8;
    localparam int SIZE   = $clog2(BEAT_B);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int OUT_W  = $clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTST);

    sched_state_e      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic [ID_W-1:0]   r_id;
    logic              r_err;
    logic              r_have;
    logic [8:0]        r_beats;
    logic [OUT_W-1:0]  r_outst;
    logic              r_awvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic [7:0]        r_awlen;
    logic [ID_W-1:0]   r_awid;
    logic              r_done_valid;
    logic [ID_W-1:0]   r_done_id;
    logic              r_busy;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any;
    logic               w_advance;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [LEN_W-1:0]   w_sel_bytes;
    logic               w_aw_hs;
    logic               w_b;
    logic [8:0]         w_beats;

    idma_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_req       (bus.req_valid),
        .i_advance   (w_advance),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_any       = |w_grant;
    assign w_advance   = (r_state == IDLE) && w_any;
    assign w_sel_addr  = bus.req_addr[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_sel_bytes = bus.req_bytes[w_grant_idx*LEN_W +: LEN_W];
    assign w_aw_hs     = r_awvalid && bus.awready;
    // B responses with nothing outstanding (e.g. left over from before a
    // reset) are ignored.
    assign w_b         = bus.bvalid && (r_outst != '0);
    assign w_beats     = calc_beats(r_addr[11:0], 32'(r_rem), 9'(MAX_BEATS), 3'(SIZE));

    assign bus.req_ready  = (r_state == IDLE) ? w_grant : '0;
    assign bus.awvalid    = r_awvalid;
    assign bus.awaddr     = r_awaddr;
    assign bus.awlen      = r_awlen;
    assign bus.awsize     = 3'(SIZE);
    assign bus.awburst    = AXI_BURST_INCR;
    assign bus.awid       = r_awid;
    assign bus.bready     = 1'b1;
    assign bus.done_valid = r_done_valid;
    assign bus.done_id    = r_done_id;
    assign bus.done_err   = r_err;
    assign bus.busy       = r_busy;

    // Outstanding-burst counter: +1 per AW handshake, -1 per B response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_outst <= '0;
        end else begin
            case ({w_aw_hs, w_b})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Descriptor FSM with registered AW and completion outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_rem        <= '0;
            r_id         <= '0;
            r_err        <= 1'b0;
            r_have       <= 1'b0;
            r_beats      <= '0;
            r_awvalid    <= 1'b0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awid       <= '0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_addr  <= w_sel_addr;
                        r_rem   <= w_sel_bytes >> SIZE;
                        r_id    <= w_grant_idx;
                        r_err   <= 1'b0;
                        r_have  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!r_have) begin
                        // Calculation cycle: size the next burst and latch it.
                        r_awaddr  <= r_addr;
                        r_awlen   <= 8'(w_beats - 9'd1);
                        r_awid    <= r_id;
                        r_beats   <= w_beats;
                        r_have    <= 1'b1;
                        r_awvalid <= (r_outst < MAX_O);
                    end else if (!r_awvalid) begin
                        // Held back by the outstanding cap; B can only free slots.
                        if (r_outst < MAX_O) r_awvalid <= 1'b1;
                    end else if (bus.awready) begin
                        r_awvalid <= 1'b0;
                        r_have    <= 1'b0;
                        r_addr    <= r_addr + (ADDR_W'(r_beats) << SIZE);
                        r_rem     <= r_rem - LEN_W'(r_beats);
                        if (r_rem == LEN_W'(r_beats)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_outst == '0) begin
                        r_done_valid <= 1'b1;
                        r_done_id    <= r_id;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_done_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_b && bus.bresp[1]) r_err <= 1'b1;
        end
    end

`ifdef IDMA_AW_SCHED_PERF_EN
    logic [31:0] r_perf_bursts;
    logic [31:0] r_perf_stall;

    // Saturating counters of AW handshakes and AW back-pressure cycles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_perf_bursts <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_aw_hs && r_perf_bursts != '1) r_perf_bursts <= r_perf_bursts + 1'b1;
            if (r_awvalid && !bus.awready && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign bus.perf_bursts = r_perf_bursts;
    assign bus.perf_stall  = r_perf_stall;
`endif

    a_bytes_legal: assert property (@(posedge aclk) disable iff (!aresetn)
        w_advance |-> (w_sel_bytes != '0 && ((w_sel_bytes >> SIZE) << SIZE) == w_sel_bytes));

    a_outst_cap: assert property (@(posedge aclk) disable iff (!aresetn)
        r_outst <= MAX_O);

endmodule

// File: tb/tb_idma_aw_burst_sched.sv
// Directed bench for idma_aw_burst_sched: single burst, 4 KB split,
// round-robin, outstanding cap, error reporting and asynchronous reset.
module tb_idma_aw_burst_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    idma_aw_burst_sched_if #(.NUM_REQ(2), .ADDR_W(32), .LEN_W(16)) bus ();

    idma_aw_burst_sched #(
        .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BEATS(16), .MAX_OUTST(4)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present a descriptor, check the one-hot ready and drop valid after the grant edge.
    task automatic start_desc(input int r, input logic [31:0] a, input logic [15:0] n);
        int t;
        bus.req_addr[r*32 +: 32]  = a;
        bus.req_bytes[r*16 +: 16] = n;
        bus.req_valid[r]          = 1'b1;
        t = 0;
        #1;
        while (bus.req_ready == '0 && t < 50) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(1 << r));
        step();
        bus.req_valid[r] = 1'b0;
    endtask

    // Wait for awvalid, check the burst, then let the handshake edge pass (awready=1).
    task automatic wait_aw(input string tag, input logic [31:0] ea, input logic [7:0] el, input logic ei);
        int t;
        t = 0;
        while (!bus.awvalid && t < 50) begin
            step();
            t++;
        end
        chk({tag, "_awvalid"}, 32'(bus.awvalid), 32'd1);
        chk({tag, "_awaddr"}, bus.awaddr, ea);
        chk({tag, "_awlen"}, 32'(bus.awlen), 32'(el));
        chk({tag, "_awid"}, 32'(bus.awid), 32'(ei));
        step();
    endtask

    task automatic send_b(input logic [1:0] resp);
        bus.bvalid = 1'b1;
        bus.bresp  = resp;
        step();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
    endtask

    task automatic wait_done(input string tag, input logic ei, input logic ee);
        int t;
        t = 0;
        while (!bus.done_valid && t < 50) begin
            step();
            t++;
        end
        chk({tag, "_done_valid"}, 32'(bus.done_valid), 32'd1);
        chk({tag, "_done_id"}, 32'(bus.done_id), 32'(ei));
        chk({tag, "_done_err"}, 32'(bus.done_err), 32'(ee));
        step();
        chk({tag, "_done_pulse"}, 32'(bus.done_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cnt [2];
        int g;
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_bytes = '0;
        bus.awready   = 1'b0;
        bus.bvalid    = 1'b0;
        bus.bresp     = 2'b00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
        chk("rst_awaddr", bus.awaddr, 32'd0);
        chk("rst_awlen", 32'(bus.awlen), 32'd0);
        chk("rst_awid", 32'(bus.awid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_done_err", 32'(bus.done_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Single descriptor: 64 bytes at 0x1000 -> one 16-beat burst, AW held by awready=0
        start_desc(0, 32'h1000, 16'd64);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_awvalid_first", 32'(bus.awvalid), 32'd0);
        step();
        chk("t1_awvalid_second", 32'(bus.awvalid), 32'd1);
        chk("t1_awaddr", bus.awaddr, 32'h1000);
        chk("t1_awlen", 32'(bus.awlen), 32'd15);
        chk("t1_awsize", 32'(bus.awsize), 32'd2);
        chk("t1_awburst", 32'(bus.awburst), 32'd1);
        chk("t1_awid", 32'(bus.awid), 32'd0);
        chk("t1_bready", 32'(bus.bready), 32'd1);
        step();
        step();
        chk("t1_hold_awvalid", 32'(bus.awvalid), 32'd1);
        chk("t1_hold_awaddr", bus.awaddr, 32'h1000);
        chk("t1_hold_awlen", 32'(bus.awlen), 32'd15);
        bus.awready = 1'b1;
        step();
        chk("t1_awvalid_after", 32'(bus.awvalid), 32'd0);
        step();
        step();
        send_b(2'b00);
        wait_done("t1", 1'b0, 1'b0);

        // 4 KB crossing: 32 bytes at 0x0FF8 -> 2 beats then 6 beats
        start_desc(0, 32'h0FF8, 16'd32);
        wait_aw("t2a", 32'h0FF8, 8'd1, 1'b0);
        wait_aw("t2b", 32'h1000, 8'd5, 1'b0);
        send_b(2'b00);
        send_b(2'b00);
        wait_done("t2", 1'b0, 1'b0);

        // Round-robin after reset: two 4-byte descriptors per requester
        apply_reset();
        step();
        bus.req_addr[31:0]  = 32'h2000;
        bus.req_addr[63:32] = 32'h3000;
        bus.req_bytes       = {16'd4, 16'd4};
        bus.req_valid       = 2'b11;
        cnt[0] = 2;
        cnt[1] = 2;
        for (int k = 0; k < 4; k++) begin
            int t;
            t = 0;
            #1;
            while (bus.req_ready == '0 && t < 50) begin
                @(posedge clk);
                #2;
                t++;
            end
            chk("rr_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            g = bus.req_ready[1] ? 1 : 0;
            step();
            cnt[g] = cnt[g] - 1;
            if (cnt[g] == 0) bus.req_valid[g] = 1'b0;
            wait_aw("rr", (k % 2 == 0) ? 32'h2000 : 32'h3000, 8'd0, (k % 2 == 1));
            send_b(2'b00);
            wait_done("rr", (k % 2 == 1), 1'b0);
        end
        bus.req_valid = '0;

        // Outstanding cap: 512 bytes at 0 -> 8 bursts of 16 beats, B held off
        start_desc(0, 32'h0, 16'd512);
        wait_aw("cap0", 32'h000, 8'd15, 1'b0);
        wait_aw("cap1", 32'h040, 8'd15, 1'b0);
        wait_aw("cap2", 32'h080, 8'd15, 1'b0);
        wait_aw("cap3", 32'h0C0, 8'd15, 1'b0);
        repeat (5) step();
        chk("cap_blocked_awvalid", 32'(bus.awvalid), 32'd0);
        chk("cap_blocked_busy", 32'(bus.busy), 32'd1);
        send_b(2'b00);
        wait_aw("cap4", 32'h100, 8'd15, 1'b0);
        send_b(2'b00);
        wait_aw("cap5", 32'h140, 8'd15, 1'b0);
        send_b(2'b00);
        wait_aw("cap6", 32'h180, 8'd15, 1'b0);
        send_b(2'b00);
        wait_aw("cap7", 32'h1C0, 8'd15, 1'b0);
        repeat (4) send_b(2'b00);
        wait_done("cap", 1'b0, 1'b0);

        // Error path: 192 bytes at 0x4000 -> 3 bursts, SLVERR on the second B
        start_desc(0, 32'h4000, 16'd192);
        wait_aw("err0", 32'h4000, 8'd15, 1'b0);
        wait_aw("err1", 32'h4040, 8'd15, 1'b0);
        wait_aw("err2", 32'h4080, 8'd15, 1'b0);
        send_b(2'b00);
        send_b(2'b10);
        send_b(2'b00);
        wait_done("err", 1'b0, 1'b1);
        start_desc(0, 32'h5000, 16'd4);
        chk("err_cleared_on_grant", 32'(bus.done_err), 32'd0);
        wait_aw("ok", 32'h5000, 8'd0, 1'b0);
        send_b(2'b00);
        wait_done("ok", 1'b0, 1'b0);

        // Asynchronous reset while a burst is being offered
        bus.awready = 1'b0;
        start_desc(1, 32'h7000, 16'd64);
        step();
        chk("ar_awvalid_before", 32'(bus.awvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_awvalid", 32'(bus.awvalid), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done_valid", 32'(bus.done_valid), 32'd0);
        step();
        rst_n       = 1'b1;
        bus.awready = 1'b1;
        step();
        start_desc(0, 32'h6000, 16'd4);
        wait_aw("ar", 32'h6000, 8'd0, 1'b0);
        send_b(2'b00);
        wait_done("ar", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idma_aw_burst_sched.md
Name: idma_aw_burst_sched

Overview:
- Write-address-channel scheduler for the chip's DMA master port.
- Accepts write descriptors (start address, byte count) from NUM_REQ requesters and grants them round-robin, one descriptor at a time.
- Splits each descriptor into AXI4 INCR bursts that respect the maximum burst length and never cross a 4 KB boundary.
- Drives the AW channel, tracks outstanding B responses, and reports per-descriptor completion and error status.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: AXI data width in bits. BEAT_B = DATA_W/8 bytes per beat.
- LEN_W, 16: width of the descriptor byte count.
- MAX_BEATS, 16: maximum beats per burst (1..256).
- MAX_OUTST, 4: maximum bursts issued but not yet answered on B.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  descriptor valid, one bit per requester.
- req_ready  out  NUM_REQ  descriptor accepted (one-hot, single cycle).
- req_addr  in  NUM_REQ*ADDR_W  start address, BEAT_B-aligned.
- req_bytes  in  NUM_REQ*LEN_W  byte count; nonzero multiple of BEAT_B.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- awaddr  out  ADDR_W  burst address.
- awlen  out  8  beats-1.
- awsize  out  3  log2(BEAT_B), constant.
- awburst  out  2  constant 2'b01 (INCR).
- awid  out  $clog2(NUM_REQ)  index of the granted requester.
- bvalid  in  1  B valid.
- bready  out  1  B ready; tied high.
- bresp  in  2  B response.
- done_valid  out  1  one-cycle pulse when a descriptor is complete.
- done_id  out  $clog2(NUM_REQ)  requester index of the completed descriptor.
- done_err  out  1  any B response for the descriptor was not OKAY.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: awvalid=0, awaddr=0, awlen=0, awid=0, req_ready=0, done_valid=0, done_id=0, done_err=0, busy=0, RR pointer=0, outstanding=0, FSM=IDLE.
- Reset asserted mid-operation: all state clears immediately. B responses still in flight are not accounted for afterwards.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the RR pointer.
  - Pulse req_ready for that requester in the same cycle and latch its addr, bytes and id.
  - RR pointer <= grant+1, modulo NUM_REQ. Go to ISSUE.
- ISSUE:
  - beats = min(rem_beats, MAX_BEATS, (4096 - addr[11:0]) / BEAT_B).
  - The burst is computed one cycle after entry; awvalid rises on the second cycle in ISSUE.
  - awvalid requires outstanding < MAX_OUTST.
  - awaddr/awlen/awid stay stable while awvalid && !awready.
  - On handshake: addr += beats*BEAT_B, rem_beats -= beats, outstanding++.
  - When rem_beats reaches 0, go to DRAIN.
- DRAIN: wait for outstanding==0, then go to DONE.
- DONE: done_valid=1 for one cycle with done_id and done_err, then go to IDLE. done_err clears on the next grant.
- Counters and error:
  - outstanding decrements on each bvalid (bready is always 1).
  - Same-cycle AW handshake and B response: outstanding is unchanged.
  - outstanding never exceeds MAX_OUTST.
  - bresp[1]=1 sets a sticky error for the current descriptor.
- Only one descriptor is in flight at a time. Other requesters wait with req_ready low.
- A byte count that is zero or not a multiple of BEAT_B is illegal input. Behaviour is undefined; the SVA flags it.

Optional Feature:
- Macro: IDMA_AW_SCHED_PERF_EN.
- Defined: adds outputs perf_bursts (32 bits, counts AW handshakes) and perf_stall (32 bits, counts cycles with awvalid && !awready). Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package idma_sched_pkg holds:
  - typedef of the FSM state enum {IDLE, ISSUE, DRAIN, DONE};
  - constants AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, PAGE_BYTES=4096;
  - function calc_beats(addr, rem, max).
- One sub-module: idma_rr_arbiter (parameter NUM_REQ; inputs req, advance; outputs one-hot grant, grant index; holds the RR pointer).

Test Plan:
- Single descriptor, req0 addr 0x1000, bytes 64, B after 2 cycles:
  - expect one AW with awaddr=0x1000, awlen=15, awsize=2, awburst=1, awid=0;
  - then done_valid with done_id=0, done_err=0.
- 4 KB crossing, addr 0x0FF8, bytes 32:
  - expect two bursts: 0x0FF8 with awlen=1, then 0x1000 with awlen=5.
- Round-robin, req0 and req1 valid together after reset, each with 2 descriptors:
  - expect grant order 0,1,0,1 and awid matching each grant.
- Outstanding cap, bytes 512 at 0x0, bvalid held low:
  - expect exactly 4 AW handshakes, then awvalid=0;
  - releasing one B allows the 5th burst;
  - after all 8 B responses, done_valid.
- Error path, 3-burst descriptor with bresp=2'b10 on the 2nd B:
  - expect done_err=1;
  - the next descriptor completes with done_err=0.
- Reset mid-ISSUE with awvalid=1, aresetn pulsed low:
  - expect awvalid=0, busy=0, done_valid=0 asynchronously;
  - next descriptor is granted to req0 and starts cleanly.
